conv_seq_ctrl: RTL and testbench

Sequencer that drives the 3x3 convolution datapath (input buffer plus PE array) over a whole image. On a start command it latches a 3x3 kernel and walks every valid (stride-1, no-padding) window in raster order. For each window it fetches nine pixels from an 8-bit pixel memory, streams three 24-bit row beats with `send`, waits for `fin`, and writes the 16-bit result to a result memory. It sits between the system control/memories and the conv datapath.

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_win_addr.sv | 53 +++++
 rtl/conv_seq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer.
// The optional ReLU clamp on results is enabled with CONV_SEQ_RELU_EN.
package conv_pkg;

    localparam int PIX_W  = 8;
    localparam int ROW_W  = 24;
    localparam int RES_W  = 16;
    localparam int KDIM   = 3;
    localparam int KCFG_W = PIX_W * KDIM * KDIM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_WAIT,
        S_WRITE,
        S_DONE
    } conv_state_t;

    // Row r of a packed 3x3 byte array; element (r,c) sits at bits [8*(3r+c)+:8].
    function automatic logic [ROW_W-1:0] kernel_row(input logic [KCFG_W-1:0] cfg,
                                                    input logic [1:0]        r);
        logic [ROW_W-1:0] row;
        case (r)
            2'd0:    row = cfg[0*ROW_W +: ROW_W];
            2'd1:    row = cfg[1*ROW_W +: ROW_W];
            default: row = cfg[2*ROW_W +: ROW_W];
        endcase
        return row;
    endfunction

endpackage

// File: rtl/conv_win_addr.sv
// Window position counters and address generation for the convolution
// sequencer: pixel fetch address, result address and last-window flag.
module conv_win_addr
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    input  logic [1:0]    row,
    input  logic [1:0]    col,
    output logic [AW-1:0] pix_addr,
    output logic [AW-1:0] res_addr,
    output logic          last_win
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] OX_LAST = XW'(IMG_W - 3);
    localparam logic [YW-1:0] OY_LAST = YW'(IMG_H - 3);

    logic [XW-1:0] ox;
    logic [YW-1:0] oy;

    // Raster-order window position: ox runs fastest, wraps into oy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ox <= '0;
            oy <= '0;
        end else if (clear) begin
            ox <= '0;
            oy <= '0;
        end else if (advance) begin
            if (ox == OX_LAST) begin
                ox <= '0;
                oy <= oy + 1'b1;
            end else begin
                ox <= ox + 1'b1;
            end
        end
    end

    assign last_win = (ox == OX_LAST) && (oy == OY_LAST);

    // Address math is unsigned and deliberately truncated to AW bits.
    assign pix_addr = (AW'(oy) + AW'(row)) * AW'(IMG_W) + AW'(ox) + AW'(col);
    assign res_addr = AW'(oy) * AW'(IMG_W - 2) + AW'(ox);

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the 3x3 convolution datapath: fetches each valid window,
// streams three row beats, waits for the result and writes it back.
// Optional feature macro: CONV_SEQ_RELU_EN (clamp negative results to zero).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | strobes low, waiting for start
// FETCH   | 9 pixel reads (row-major) plus one drain cycle
// SEND    | three beats of window row / kernel row with send=1
// WAIT    | waiting for conv_fin, bounded by the timeout down-counter
// WRITE   | one-cycle result write, advance window position
// DONE    | one-cycle done pulse, then back to IDLE
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int AW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KCFG_W-1:0] wt_cfg,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              pix_rd,
    output logic [AW-1:0]     pix_addr,
    input  logic [PIX_W-1:0]  pix_rdata,
    output logic [ROW_W-1:0]  data,
    output logic [ROW_W-1:0]  wt,
    output logic              send,
    input  logic [RES_W-1:0]  conv_out,
    input  logic              conv_fin,
    output logic              res_we,
    output logic [AW-1:0]     res_addr,
    output logic [RES_W-1:0]  res_data
);

    localparam logic [3:0] FETCH_LAST = 4'd9;
    localparam logic [3:0] PIX_LAST   = 4'd8;
    localparam logic [3:0] SEND_LAST  = 4'd2;
    localparam int         TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLOAD   = TW'(TIMEOUT - 1);

    conv_state_t       state, state_nxt;
    logic [3:0]        pcnt;
    logic [TW-1:0]     tcnt;
    logic [KCFG_W-1:0] win;
    logic [KCFG_W-1:0] wt_q;
    logic              cap_vld;
    logic [3:0]        cap_idx;
    logic [RES_W-1:0]  res_q;
    logic [RES_W-1:0]  res_cap;
    logic              err_q;
    logic              accept;
    logic              fin_hit;
    logic              timeout;
    logic [1:0]        fetch_row;
    logic [1:0]        fetch_col;
    logic [AW-1:0]     addr_pix;
    logic [AW-1:0]     addr_res;
    logic              last_win;

    assign accept  = (state == S_IDLE) && start;
    assign fin_hit = (state == S_WAIT) && conv_fin;
    assign timeout = (state == S_WAIT) && !conv_fin && (tcnt == '0);

`ifdef CONV_SEQ_RELU_EN
    assign res_cap = conv_out[RES_W-1] ? '0 : conv_out;
`else
    assign res_cap = conv_out;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_FETCH;
            S_FETCH: if (pcnt == FETCH_LAST) state_nxt = S_SEND;
            S_SEND:  if (pcnt == SEND_LAST) state_nxt = S_WAIT;
            S_WAIT: begin
                if (fin_hit)      state_nxt = S_WRITE;
                else if (timeout) state_nxt = S_IDLE;
            end
            S_WRITE: state_nxt = last_win ? S_DONE : S_FETCH;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Phase counter shared by FETCH (0..9) and SEND (0..2); zero elsewhere.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
        end else if ((state == S_FETCH && pcnt != FETCH_LAST) ||
                     (state == S_SEND  && pcnt != SEND_LAST)) begin
            pcnt <= pcnt + 1'b1;
        end else begin
            pcnt <= '0;
        end
    end

    // Timeout down-counter: preloaded outside WAIT, terminal count at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                tcnt <= TLOAD;
        else if (state == S_WAIT) tcnt <= tcnt - 1'b1;
        else                     tcnt <= TLOAD;
    end

    // Kernel latch and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wt_q  <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            wt_q  <= wt_cfg;
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    // Window register fill: read data lands one cycle after its strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_vld <= 1'b0;
            cap_idx <= '0;
            win     <= '0;
        end else begin
            cap_vld <= pix_rd;
            cap_idx <= pcnt;
            if (cap_vld) win[PIX_W*cap_idx +: PIX_W] <= pix_rdata;
        end
    end

    // Result capture; conv_fin is only honoured while in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         res_q <= '0;
        else if (fin_hit) res_q <= res_cap;
    end

    // Map the fetch phase onto the (row, col) offset within the window.
    always_comb begin
        fetch_row = 2'd0;
        fetch_col = pcnt[1:0];
        if (pcnt >= 4'd6) begin
            fetch_row = 2'd2;
            fetch_col = 2'(pcnt - 4'd6);
        end else if (pcnt >= 4'd3) begin
            fetch_row = 2'd1;
            fetch_col = 2'(pcnt - 4'd3);
        end
    end

    conv_win_addr #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) u_win_addr (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .advance  (state == S_WRITE),
        .row      (fetch_row),
        .col      (fetch_col),
        .pix_addr (addr_pix),
        .res_addr (addr_res),
        .last_win (last_win)
    );

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign err      = err_q;
    assign pix_rd   = (state == S_FETCH) && (pcnt <= PIX_LAST);
    assign pix_addr = pix_rd ? addr_pix : '0;
    assign send     = (state == S_SEND);
    assign data     = send ? kernel_row(win, pcnt[1:0]) : '0;
    assign wt       = send ? kernel_row(wt_q, pcnt[1:0]) : '0;
    assign res_we   = (state == S_WRITE);
    assign res_addr = res_we ? addr_res : '0;
    assign res_data = res_we ? res_q : '0;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl on a 4x4 image: pixel memory returns pixel(a)=a,
// datapath model sums data*wt over the three beats and answers in the
// second WAIT cycle.
module tb_conv_seq_ctrl;

    localparam int IMG_W   = 4;
    localparam int IMG_H   = 4;
    localparam int AW      = 8;
    localparam int TIMEOUT = 64;

    localparam logic [71:0] W_ONES = 72'h01_01_01_01_01_01_01_01_01;
    localparam logic [71:0] W_SEQ  = 72'h09_08_07_06_05_04_03_02_01;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [71:0]   wt_cfg = '0;
    logic          busy, done, err, pix_rd, send, res_we;
    logic [AW-1:0] pix_addr, res_addr;
    logic [7:0]    pix_rdata = '0;
    logic [23:0]   data, wt;
    logic [15:0]   conv_out = '0;
    logic          conv_fin = 1'b0;
    logic [15:0]   res_data;

    conv_seq_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .wt_cfg(wt_cfg),
        .busy(busy), .done(done), .err(err),
        .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_rdata(pix_rdata),
        .data(data), .wt(wt), .send(send),
        .conv_out(conv_out), .conv_fin(conv_fin),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [AW-1:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic [23:0] d; logic [23:0] w; } beat_t;
    typedef struct { logic [AW-1:0] addr; logic [15:0] data; } wvec_t;
    typedef struct { logic [23:0] d; logic [23:0] w; } bvec_t;

    wr_t   wr_q[$];
    beat_t beat_q[$];

    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   busy_rise = -1;
    int   busy_fall = -1;
    logic busy_d = 1'b0;

    logic        reset_phase = 1'b1;
    logic        dp_nofin = 1'b0;
    logic        dp_force = 1'b0;
    logic [15:0] dp_force_val = '0;

    int n_checks = 0;
    int n_fail = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pixel memory: read data for a strobe appears in the following cycle.
    initial begin : pix_model
        logic          pend_v;
        logic [AW-1:0] pend_a;
        pend_v = 1'b0;
        pend_a = '0;
        forever begin
            @(negedge clk);
            if (reset_phase) pix_rdata = 8'($urandom);
            else             pix_rdata = pend_v ? pend_a[7:0] : 8'h00;
            pend_v = pix_rd;
            pend_a = pix_addr;
        end
    end

    // Datapath: accumulate the three beats, raise fin in the 2nd WAIT cycle.
    initial begin : dp_model
        int beats, wcnt, sum;
        beats = 0; wcnt = 0; sum = 0;
        forever begin
            @(negedge clk);
            if (reset_phase) begin
                conv_fin = 1'($urandom);
                conv_out = 16'($urandom);
                beats = 0; wcnt = 0; sum = 0;
            end else if (!rst) begin
                conv_fin = 1'b0;
                conv_out = '0;
                beats = 0; wcnt = 0; sum = 0;
            end else begin
                conv_fin = 1'b0;
                if (send) begin
                    if (beats == 0) sum = 0;
                    beat_q.push_back('{d: data, w: wt});
                    for (int c = 0; c < 3; c++)
                        sum += int'(data[8*c +: 8]) * int'(wt[8*c +: 8]);
                    beats++;
                    if (beats == 3) begin
                        beats = 0;
                        wcnt = 2;
                    end
                end else if (wcnt > 0) begin
                    wcnt--;
                    if (wcnt == 0 && !dp_nofin) begin
                        conv_fin = 1'b1;
                        conv_out = dp_force ? dp_force_val : 16'(sum);
                    end
                end
            end
        end
    end

    // Output monitor.
    initial forever begin
        @(negedge clk);
        if (res_we) wr_q.push_back('{cyc: cyc, addr: res_addr, data: res_data});
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy && !busy_d) busy_rise = cyc;
        if (!busy && busy_d) busy_fall = cyc;
        busy_d = busy;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic wr_t get_wr(input int i);
        wr_t w;
        w = '{cyc: -1, addr: {AW{1'b1}}, data: 16'hDEAD};
        if (i < wr_q.size()) w = wr_q[i];
        return w;
    endfunction

    function automatic beat_t get_beat(input int i);
        beat_t b;
        b = '{d: 24'hDEAD00, w: 24'hDEAD00};
        if (i < beat_q.size()) b = beat_q[i];
        return b;
    endfunction

    task automatic do_start(input logic [71:0] cfg);
        @(negedge clk); #1;
        check("busy_low_before_start", busy, 1'b0);
        wt_cfg = cfg;
        start  = 1'b1;
        @(negedge clk); #1;
        start  = 1'b0;
        check("busy_high_after_start", busy, 1'b1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    initial begin : main
        wvec_t exp_ones[4];
        bvec_t exp_beats[3];
        int    wb, bb, dc, n;
        logic [15:0] relu_exp;

        exp_ones[0] = '{addr: 8'd0, data: 16'd45};
        exp_ones[1] = '{addr: 8'd1, data: 16'd54};
        exp_ones[2] = '{addr: 8'd2, data: 16'd81};
        exp_ones[3] = '{addr: 8'd3, data: 16'd90};
        exp_beats[0] = '{d: 24'h020100, w: 24'h030201};
        exp_beats[1] = '{d: 24'h060504, w: 24'h060504};
        exp_beats[2] = '{d: 24'h0A0908, w: 24'h090807};
`ifdef CONV_SEQ_RELU_EN
        relu_exp = 16'h0000;
`else
        relu_exp = 16'hFFF6;
`endif

        // Reset held with random inputs: every output stays zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start  = 1'($urandom);
            wt_cfg = 72'({$urandom, $urandom, $urandom});
            #1;
            check("reset_strobes", {busy, done, err, pix_rd, send, res_we}, 6'b0);
            check("reset_buses", {pix_addr, res_addr, data, wt, res_data}, '0);
        end
        @(negedge clk);
        start = 1'b0;
        wt_cfg = '0;
        reset_phase = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("idle_after_reset", {busy, done, err, pix_rd, send, res_we}, 6'b0);
        end

        // Single run, all weights 1.
        wb = wr_q.size();
        dc = done_cnt;
        do_start(W_ONES);
        wait_idle(200, "single_run_idle");
        check("single_write_count", wr_q.size() - wb, 4);
        for (int i = 0; i < 4; i++) begin
            check("single_res_addr", get_wr(wb + i).addr, exp_ones[i].addr);
            check("single_res_data", get_wr(wb + i).data, exp_ones[i].data);
        end
        check("first_write_latency", get_wr(wb).cyc - busy_rise, 15);
        for (int i = 1; i < 4; i++)
            check("window_period", get_wr(wb + i).cyc - get_wr(wb + i - 1).cyc, 16);
        check("single_done_count", done_cnt - dc, 1);
        check("done_after_last_write", done_cyc - get_wr(wb + 3).cyc, 1);
        check("busy_fall_after_done", busy_fall - done_cyc, 1);
        check("single_err", err, 1'b0);

        // Beat format with distinct kernel weights.
        wb = wr_q.size();
        bb = beat_q.size();
        do_start(W_SEQ);
        wait_idle(200, "beat_run_idle");
        for (int i = 0; i < 3; i++) begin
            check("beat_data", get_beat(bb + i).d, exp_beats[i].d);
            check("beat_wt", get_beat(bb + i).w, exp_beats[i].w);
        end
        check("weighted_result_w0", get_wr(wb).data, 16'd303);

        // Timeout: datapath never answers.
        wb = wr_q.size();
        dc = done_cnt;
        dp_nofin = 1'b1;
        do_start(W_ONES);
        wait_idle(300, "timeout_idle");
        check("timeout_err", err, 1'b1);
        check("timeout_no_write", wr_q.size() - wb, 0);
        check("timeout_no_done", done_cnt - dc, 0);
        check("timeout_busy_len", busy_fall - busy_rise, 13 + TIMEOUT);
        dp_nofin = 1'b0;
        wb = wr_q.size();
        do_start(W_ONES);
        check("err_cleared_by_start", err, 1'b0);
        wait_idle(200, "after_timeout_idle");
        check("after_timeout_writes", wr_q.size() - wb, 4);

        // Negative result, ReLU dependent.
        wb = wr_q.size();
        dp_force = 1'b1;
        dp_force_val = 16'hFFF6;
        do_start(W_ONES);
        wait_idle(200, "relu_idle");
        dp_force = 1'b0;
        check("relu_data", get_wr(wb).data, relu_exp);
        check("relu_addr", get_wr(wb).addr, 8'd0);

        // Start during SEND is ignored.
        wb = wr_q.size();
        dc = done_cnt;
        do_start(W_ONES);
        n = 0;
        while (!send && n < 50) begin @(negedge clk); #1; n++; end
        check("reached_send", send, 1'b1);
        wt_cfg = '0;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_idle(200, "ignore_start_idle");
        check("ignore_start_writes", wr_q.size() - wb, 4);
        check("ignore_start_first", get_wr(wb).data, 16'd45);
        check("ignore_start_last", get_wr(wb + 3).data, 16'd90);
        check("ignore_start_done", done_cnt - dc, 1);

        // Reset during WAIT of window 2, then restart from window 0.
        wb = wr_q.size();
        do_start(W_ONES);
        n = 0;
        while (wr_q.size() < wb + 2 && n < 200) begin @(negedge clk); #1; n++; end
        n = 0;
        while (!send && n < 50) begin @(negedge clk); #1; n++; end
        n = 0;
        while (send && n < 50) begin @(negedge clk); #1; n++; end
        check("abort_point_writes", wr_q.size() - wb, 2);
        rst = 1'b0;
        #1;
        check("abort_outputs_zero", {busy, done, err, pix_rd, send, res_we}, 6'b0);
        @(negedge clk); #1;
        rst = 1'b1;
        check("abort_no_extra_write", wr_q.size() - wb, 2);
        wb = wr_q.size();
        do_start(W_ONES);
        wait_idle(200, "restart_idle");
        check("restart_first_addr", get_wr(wb).addr, 8'd0);
        check("restart_first_data", get_wr(wb).data, 16'd45);
        check("restart_writes", wr_q.size() - wb, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
